serial_adder: RTL and testbench

- Bit-serial ripple adder: the additive counterpart of the team's full-subtractor cell.
- Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake.
- Resolves one bit per clock with a single full-adder slice and a carry flip-flop.
- Returns sum, carry-out and signed-overflow through a second valid/ready handshake.
- Used where area matters more than latency: accumulators and checksum paths.

---
 rtl/serial_adder_if.sv | 29 ++
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand channel (in_*, a, b, cin)
// and result channel (out_*, sum, cout, ovf), plus the busy status flag.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Adder side: consumes operands, produces the result.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, sum, cout, ovf, out_valid, busy
  );

  // Client side: supplies operands, consumes the result.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, sum, cout, ovf, out_valid, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. One full-adder slice plus a carry flop resolve one
// operand bit per clock, LSB first. {cout,sum} = a + b + cin; ovf flags
// two's-complement overflow (carry into MSB xor carry out of MSB).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  // Single full-adder slice operating on the bit selected by the counter.
  logic bit_a, bit_b, slice_sum, slice_carry;

  assign bit_a       = a_reg[cnt_reg];
  assign bit_b       = b_reg[cnt_reg];
  assign slice_sum   = bit_a ^ bit_b ^ carry_reg;
  assign slice_carry = (bit_a & bit_b) | (bit_a & carry_reg) | (bit_b & carry_reg);

  // Sum register image with only the current bit replaced; untouched bits
  // keep their value, so not-yet-computed bits stay at the zero loaded on accept.
  logic [WIDTH-1:0] sum_upd;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_bit
      assign sum_upd[gi] = (cnt_reg == CW'(gi)) ? slice_sum : sum_reg[gi];
    end
  endgenerate

  // Next-state logic: accept in IDLE, one bit per edge in RUN, hold in DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = RUN;
          a_next     = bus.a;
          b_next     = bus.b;
          carry_next = bus.cin;
          cnt_next   = '0;
          sum_next   = '0;
          cout_next  = 1'b0;
          ovf_next   = 1'b0;
        end
      end

      RUN: begin
        sum_next   = sum_upd;
        carry_next = slice_carry;
        if (cnt_reg == LAST_BIT) begin
          // carry_reg here is the carry into the MSB, slice_carry the carry out.
          state_next = DONE;
          cout_next  = slice_carry;
          ovf_next   = carry_reg ^ slice_carry;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  // in_ready is gated by rst_n so it drops immediately in reset and rises
  // as soon as reset is released, without waiting for a clock edge.
  assign bus.in_ready  = (state_reg == IDLE) && rst_n;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, backpressure
// and mid-operation reset sequences, random regression at WIDTH 8 and 16.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8();
  serial_adder_if #(.WIDTH(16)) bus16();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full WIDTH=8 transaction: present operands, wait for out_valid,
  // stall 'stall' cycles, then release the result.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input int stall, output logic [7:0] rs, output logic rc,
                     output logic rv, output int lat);
    @(negedge clk);
    bus8.a = ta; bus8.b = tb_; bus8.cin = tc; bus8.in_valid = 1'b1;
    chk("in_ready_idle8", 32'(bus8.in_ready), 32'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus8.out_valid) break;
    end
    rs = bus8.sum; rc = bus8.cout; rv = bus8.ovf;
    repeat (stall) @(posedge clk);
    #1;
    chk("hold_sum8", 32'(bus8.sum), 32'(rs));
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                      input int stall, output logic [15:0] rs, output logic rc,
                      output logic rv, output int lat);
    @(negedge clk);
    bus16.a = ta; bus16.b = tb_; bus16.cin = tc; bus16.in_valid = 1'b1;
    chk("in_ready_idle16", 32'(bus16.in_ready), 32'd1);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus16.out_valid) break;
    end
    rs = bus16.sum; rc = bus16.cout; rv = bus16.ovf;
    repeat (stall) @(posedge clk);
    #1;
    chk("hold_sum16", 32'(bus16.sum), 32'(rs));
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  rs8;
    logic [15:0] rs16;
    logic        rc, rv;
    int          lat;
    logic [8:0]  ref9;
    logic [16:0] ref17;
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic        rcin;
    logic        eovf;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_cout_ovf", 32'({bus8.cout, bus8.ovf}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus8.in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, 0, rs8, rc, rv, lat);
      $display("vec %0d: %h+%h+%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, rs8, rc, rv, lat);
      chk("vec_latency", 32'(lat), 32'd8);
      chk("vec_sum", 32'(rs8), 32'(vecs[i].sum));
      chk("vec_cout", 32'(rc), 32'(vecs[i].cout));
      chk("vec_ovf", 32'(rv), 32'(vecs[i].ovf));
    end

    // Backpressure with ignored input during RUN and DONE: 3C+42 = 7E
    @(negedge clk);
    bus8.a = 8'h3C; bus8.b = 8'h42; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_ready_run", 32'(bus8.in_ready), 32'd0);
    end
    chk("bp_valid", 32'(bus8.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_sum", 32'(bus8.sum), 32'h7E);
      chk("bp_hold_flags", 32'({bus8.out_valid, bus8.cout, bus8.ovf}), 32'b100);
      chk("bp_ready_done", 32'(bus8.in_ready), 32'd0);
    end
    $display("backpressure: sum=%h held 5 cycles", bus8.sum);
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("bp_release_ready", 32'(bus8.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus8.out_valid), 32'd0);

    // Reset in the middle of RUN
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(bus8.sum), 32'd0);
    chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus8.in_ready), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(bus8.in_ready), 32'd1);
    op8(8'h01, 8'h02, 1'b0, 0, rs8, rc, rv, lat);
    $display("post-reset: 01+02 -> sum=%h lat=%0d", rs8, lat);
    chk("post_rst_sum", 32'(rs8), 32'h03);
    chk("post_rst_lat", 32'(lat), 32'd8);

    // Random regression WIDTH=8
    for (int n = 0; n < 1000; n++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rcin = 1'($urandom);
      op8(ra8, rb8, rcin, $urandom_range(0, 3), rs8, rc, rv, lat);
      ref9 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rcin};
      eovf = (ra8[7] == rb8[7]) && (ref9[7] != ra8[7]);
      $display("r8 %0d: %h+%h+%0d -> %h/%0d/%0d", n, ra8, rb8, rcin, rs8, rc, rv);
      chk("r8_lat", 32'(lat), 32'd8);
      chk("r8_result", 32'({rc, rs8}), 32'(ref9));
      chk("r8_ovf", 32'(rv), 32'(eovf));
    end

    // Random regression WIDTH=16
    for (int n = 0; n < 1000; n++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rcin = 1'($urandom);
      op16(ra16, rb16, rcin, $urandom_range(0, 3), rs16, rc, rv, lat);
      ref17 = {1'b0, ra16} + {1'b0, rb16} + {16'd0, rcin};
      eovf = (ra16[15] == rb16[15]) && (ref17[15] != ra16[15]);
      $display("r16 %0d: %h+%h+%0d -> %h/%0d/%0d", n, ra16, rb16, rcin, rs16, rc, rv);
      chk("r16_lat", 32'(lat), 32'd16);
      chk("r16_result", 32'({rc, rs16}), 32'(ref17));
      chk("r16_ovf", 32'(rv), 32'(eovf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
